// File: rtl/sram_1rw1r_arbiter_if.sv
// Requester (A, B, R) and 1RW1R SRAM macro pin bundle for sram_1rw1r_arbiter.
// collision_cnt exists only when SRAM_ARB_COLLISION_EN is defined.
interface sram_1rw1r_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
);
  logic                  a_valid;
  logic                  a_ready;
  logic                  a_we;
  logic [NUM_WMASKS-1:0] a_wmask;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_valid;
  logic                  b_ready;
  logic                  b_we;
  logic [NUM_WMASKS-1:0] b_wmask;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic                  r_valid;
  logic                  r_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  sram_csb0;
  logic                  sram_web0;
  logic [NUM_WMASKS-1:0] sram_wmask0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  logic [DATA_WIDTH-1:0] sram_din0;
  logic [DATA_WIDTH-1:0] sram_dout0;
  logic                  sram_csb1;
  logic [ADDR_WIDTH-1:0] sram_addr1;
  logic [DATA_WIDTH-1:0] sram_dout1;
`ifdef SRAM_ARB_COLLISION_EN
  logic [15:0]           collision_cnt;
`endif

  modport slave (
    input  a_valid, a_we, a_wmask, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_wmask, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata,
    input  r_valid, r_addr,
    output r_ready, r_rvalid, r_rdata,
    output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
    input  sram_dout0,
    output sram_csb1, sram_addr1,
    input  sram_dout1
`ifdef SRAM_ARB_COLLISION_EN
    , output collision_cnt
`endif
  );

  modport master (
    output a_valid, a_we, a_wmask, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_wmask, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata,
    output r_valid, r_addr,
    input  r_ready, r_rvalid, r_rdata,
    input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
    output sram_dout0,
    input  sram_csb1, sram_addr1,
    output sram_dout1
`ifdef SRAM_ARB_COLLISION_EN
    , input collision_cnt
`endif
  );
endinterface

// File: rtl/sram_1rw1r_arbiter.sv
// Round-robin A/B arbiter onto RW port 0 plus R pass-through onto port 1 of a 1RW1R SRAM.
// Optional SRAM_ARB_COLLISION_EN stalls R on a same-address port-0 write and counts stalls.
module sram_1rw1r_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
) (
  input  logic                 clk,
  input  logic                 rstb,
  sram_1rw1r_arbiter_if.slave  bus
);

  typedef enum logic {OWNER_A, OWNER_B} owner_t;

  owner_t                last_grant;
  logic                  tag_e1_valid;
  owner_t                tag_e1_owner;
  logic                  tag_e2_valid;
  owner_t                tag_e2_owner;
  logic                  r_tag_e1;
  logic                  r_tag_e2;

  logic                  grant_a;
  logic                  grant_b;
  logic                  p0_accept;
  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  r_accept;

  always_comb begin
    grant_a   = bus.a_valid && (!bus.b_valid || last_grant == OWNER_B);
    grant_b   = bus.b_valid && !grant_a;
    p0_accept = grant_a || grant_b;
    sel_we    = grant_a ? bus.a_we    : bus.b_we;
    sel_wmask = grant_a ? bus.a_wmask : bus.b_wmask;
    sel_addr  = grant_a ? bus.a_addr  : bus.b_addr;
    sel_wdata = grant_a ? bus.a_wdata : bus.b_wdata;
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

`ifdef SRAM_ARB_COLLISION_EN
  logic collision;
  // Holding R off one cycle lets it sample the macro after the write has landed.
  assign collision   = p0_accept && sel_we && bus.r_valid && (bus.r_addr == sel_addr);
  assign bus.r_ready = !collision;
`else
  assign bus.r_ready = 1'b1;
`endif

  assign r_accept = bus.r_valid && bus.r_ready;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bus.sram_csb0   <= 1'b1;
      bus.sram_web0   <= 1'b1;
      bus.sram_wmask0 <= '0;
      bus.sram_addr0  <= '0;
      bus.sram_din0   <= '0;
      bus.sram_csb1   <= 1'b1;
      bus.sram_addr1  <= '0;
      last_grant      <= OWNER_B;
      tag_e1_valid    <= 1'b0;
      tag_e1_owner    <= OWNER_A;
      tag_e2_valid    <= 1'b0;
      tag_e2_owner    <= OWNER_A;
      r_tag_e1        <= 1'b0;
      r_tag_e2        <= 1'b0;
      bus.a_rvalid    <= 1'b0;
      bus.a_rdata     <= '0;
      bus.b_rvalid    <= 1'b0;
      bus.b_rdata     <= '0;
      bus.r_rvalid    <= 1'b0;
      bus.r_rdata     <= '0;
`ifdef SRAM_ARB_COLLISION_EN
      bus.collision_cnt <= '0;
`endif
    end else begin
      bus.sram_csb0 <= !p0_accept;
      bus.sram_web0 <= !(p0_accept && sel_we);
      if (p0_accept) begin
        bus.sram_wmask0 <= sel_wmask;
        bus.sram_addr0  <= sel_addr;
        bus.sram_din0   <= sel_wdata;
        last_grant      <= grant_a ? OWNER_A : OWNER_B;
      end

      // Tag rides alongside the command: issued (E0), sampled by macro (E1), data captured (E2).
      tag_e1_valid <= p0_accept && !sel_we;
      tag_e1_owner <= grant_a ? OWNER_A : OWNER_B;
      tag_e2_valid <= tag_e1_valid;
      tag_e2_owner <= tag_e1_owner;

      bus.a_rvalid <= tag_e2_valid && (tag_e2_owner == OWNER_A);
      bus.b_rvalid <= tag_e2_valid && (tag_e2_owner == OWNER_B);
      if (tag_e2_valid) begin
        if (tag_e2_owner == OWNER_A) bus.a_rdata <= bus.sram_dout0;
        else                         bus.b_rdata <= bus.sram_dout0;
      end

      bus.sram_csb1 <= !r_accept;
      if (r_accept) bus.sram_addr1 <= bus.r_addr;
      r_tag_e1     <= r_accept;
      r_tag_e2     <= r_tag_e1;
      bus.r_rvalid <= r_tag_e2;
      if (r_tag_e2) bus.r_rdata <= bus.sram_dout1;

`ifdef SRAM_ARB_COLLISION_EN
      if (collision && bus.collision_cnt != '1)
        bus.collision_cnt <= bus.collision_cnt + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// Scoreboard bench for sram_1rw1r_arbiter: shadow-memory reference, SRAM macro model,
// directed scenarios followed by randomized traffic.
module tb_sram_1rw1r_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  sram_1rw1r_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(MW)) bus ();

  sram_1rw1r_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(MW)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    return (i * 32'h0101_0101) ^ 32'hA5C3_5A3C;
  endfunction

  // SRAM macro model: samples pins on the rising edge, read data appears after that edge.
  logic [DW-1:0] mem [256];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (!bus.sram_csb0) begin
        if (!bus.sram_web0) begin
          for (int i = 0; i < MW; i++)
            if (bus.sram_wmask0[i]) mem[bus.sram_addr0][8*i +: 8] <= bus.sram_din0[8*i +: 8];
        end else begin
          bus.sram_dout0 <= mem[bus.sram_addr0];
        end
      end
      if (!bus.sram_csb1) bus.sram_dout1 <= mem[bus.sram_addr1];
    end
  end

  // Reference state
  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
    bit            dc;
  } exp_t;

  logic [DW-1:0] shadow [256];
  exp_t          q [3][$];
  logic [DW-1:0] held [3];
  bit            held_ok [3];
  bit            prev_b;
  logic [15:0]   exp_coll;
  int unsigned   cyc = 0;
  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  // Monitor: every cycle compare each response channel against the scoreboard head.
  always @(negedge clk) begin : monitor
    logic          rv;
    logic [DW-1:0] rd;
    logic          exp_rv;
    exp_t          e;
    string         nm;
    if (rstb) begin
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       begin rv = bus.a_rvalid; rd = bus.a_rdata; nm = "a"; end
          1:       begin rv = bus.b_rvalid; rd = bus.b_rdata; nm = "b"; end
          default: begin rv = bus.r_rvalid; rd = bus.r_rdata; nm = "r"; end
        endcase
        exp_rv = (q[i].size() != 0) && (q[i][0].due <= cyc);
        check({nm, "_rvalid"}, 32'(rv), 32'(exp_rv));
        if (exp_rv) begin
          e = q[i].pop_front();
          if (!e.dc) check({nm, "_rdata"}, rd, e.data);
          held[i]    = e.data;
          held_ok[i] = !e.dc;
        end else if (!rv && held_ok[i]) begin
          check({nm, "_rdata_hold"}, rd, held[i]);
        end
      end
    end
  end

  task automatic set_a(input logic v, input logic we, input logic [MW-1:0] m,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bus.a_valid = v; bus.a_we = we; bus.a_wmask = m; bus.a_addr = ad; bus.a_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [MW-1:0] m,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bus.b_valid = v; bus.b_we = we; bus.b_wmask = m; bus.b_addr = ad; bus.b_wdata = d;
  endtask

  task automatic set_r(input logic v, input logic [AW-1:0] ad);
    bus.r_valid = v; bus.r_addr = ad;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);
    set_r(1'b0, '0);
  endtask

  // Called just after a falling edge with inputs set; predicts grants and responses, then
  // advances to the next falling edge (the command is accepted at the rising edge between).
  task automatic issue();
    logic          ga, gb, hit, rr, we;
    logic [MW-1:0] m;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
    exp_t          e;
    #1;
    if (bus.a_valid && bus.b_valid) begin
      ga = prev_b;
      gb = !prev_b;
    end else begin
      ga = bus.a_valid;
      gb = bus.b_valid;
    end
    check("a_ready", 32'(bus.a_ready), 32'(ga));
    check("b_ready", 32'(bus.b_ready), 32'(gb));
    hit = 1'b0;
    if (ga || gb) begin
      prev_b = gb;
      we = ga ? bus.a_we    : bus.b_we;
      m  = ga ? bus.a_wmask : bus.b_wmask;
      ad = ga ? bus.a_addr  : bus.b_addr;
      d  = ga ? bus.a_wdata : bus.b_wdata;
      if (we) begin
        for (int i = 0; i < MW; i++) if (m[i]) shadow[ad][8*i +: 8] = d[8*i +: 8];
        hit = bus.r_valid && (bus.r_addr == ad);
      end else begin
        e.data = shadow[ad]; e.due = cyc + 3; e.dc = 1'b0;
        q[ga ? 0 : 1].push_back(e);
      end
    end
`ifdef SRAM_ARB_COLLISION_EN
    rr = !hit;
    if (hit && exp_coll != 16'hFFFF) exp_coll = exp_coll + 16'd1;
`else
    rr = 1'b1;
`endif
    check("r_ready", 32'(bus.r_ready), 32'(rr));
    if (bus.r_valid && rr) begin
      e.data = shadow[bus.r_addr]; e.due = cyc + 3; e.dc = hit;
      q[2].push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    idle();
    #1;
    check("rst_csb0",   32'(bus.sram_csb0), 32'd1);
    check("rst_csb1",   32'(bus.sram_csb1), 32'd1);
    check("rst_web0",   32'(bus.sram_web0), 32'd1);
    check("rst_wmask0", 32'(bus.sram_wmask0), 32'd0);
    check("rst_addr0",  32'(bus.sram_addr0), 32'd0);
    check("rst_din0",   bus.sram_din0, 32'd0);
    check("rst_addr1",  32'(bus.sram_addr1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      held[i]    = '0;
      held_ok[i] = 1'b1;
    end
    prev_b   = 1'b1;
    exp_coll = '0;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    idle();
    @(negedge clk);
    do_reset();

    // Contention from reset: A first, then strict alternation.
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b0, '0, 8'h10 + 8'(i), '0);
      set_b(1'b1, 1'b0, '0, 8'h20 + 8'(i), '0);
      issue();
    end
    idle();

    // Write then read back, checking the registered macro pins on the way.
    set_a(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
    issue();
    check("pin_csb0_wr",  32'(bus.sram_csb0), 32'd0);
    check("pin_web0_wr",  32'(bus.sram_web0), 32'd0);
    check("pin_addr0_wr", 32'(bus.sram_addr0), 32'h10);
    check("pin_din0_wr",  bus.sram_din0, 32'hDEADBEEF);
    check("pin_wmask0",   32'(bus.sram_wmask0), 32'hF);
    set_a(1'b1, 1'b0, '0, 8'h10, '0);
    issue();
    check("pin_csb0_rd", 32'(bus.sram_csb0), 32'd0);
    check("pin_web0_rd", 32'(bus.sram_web0), 32'd1);
    idle();
    issue();
    check("pin_csb0_idle", 32'(bus.sram_csb0), 32'd1);
    check("pin_web0_idle", 32'(bus.sram_web0), 32'd1);
    check("pin_addr0_hold", 32'(bus.sram_addr0), 32'h10);
    issue();
    issue();

    // Byte mask merge.
    set_a(1'b1, 1'b1, 4'hF, 8'h20, 32'h11223344);
    issue();
    set_a(1'b1, 1'b1, 4'b0101, 8'h20, 32'hAABBCCDD);
    issue();
    set_a(1'b1, 1'b0, '0, 8'h20, '0);
    issue();
    idle();
    repeat (3) issue();

    // Same-address port-0 write and port-1 read in one cycle.
    set_a(1'b1, 1'b1, 4'hF, 8'h30, 32'h5);
    set_r(1'b1, 8'h30);
    issue();
    set_a(1'b0, 1'b0, '0, '0, '0);
    issue();
    set_r(1'b0, '0);
    set_b(1'b1, 1'b0, '0, 8'h30, '0);
    issue();
    idle();
    repeat (3) issue();
`ifdef SRAM_ARB_COLLISION_EN
    check("collision_cnt", 32'(bus.collision_cnt), 32'(exp_coll));
`endif

    // Reset with a read pair in flight: no responses may escape.
    set_a(1'b1, 1'b0, '0, 8'h10, '0);
    issue();
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b1, 1'b0, '0, 8'h20, '0);
    set_r(1'b1, 8'h40);
    issue();
    do_reset();
    repeat (4) issue();
    set_a(1'b1, 1'b0, '0, 8'h11, '0);
    set_b(1'b1, 1'b0, '0, 8'h12, '0);
    issue();
    idle();
    repeat (3) issue();

    // Streaming port-1 reads alongside port-0 reads.
    for (int i = 0; i < 8; i++) begin
      set_r(1'b1, 8'h40 + 8'(i));
      set_a(1'b1, 1'b0, '0, 8'h80 + 8'(i), '0);
      issue();
    end
    idle();
    repeat (3) issue();

    // Randomized traffic over a small address window to provoke hazards and collisions.
    for (int n = 0; n < 400; n++) begin
      set_a(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom_range(0, 7)), $urandom);
      set_b(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom_range(0, 7)), $urandom);
      set_r(1'($urandom), 8'($urandom_range(0, 7)));
      issue();
    end
    idle();
    repeat (5) issue();
`ifdef SRAM_ARB_COLLISION_EN
    check("collision_cnt_final", 32'(bus.collision_cnt), 32'(exp_coll));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
